// File: rtl/rr_mux_arbiter_2to1_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter_2to1_pkg
// Shared encodings for the 2-requester packet arbiter and its mux slice.
//   ST_IDLE / ST_LOCK   : arbiter FSM state encoding
//   OWN_REQ0 / OWN_REQ1 : owner encoding, also the mux select value
//   clog2()             : beat-counter width helper (never returns less than 1)
// -----------------------------------------------------------------------------
package rr_mux_arbiter_2to1_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_LOCK  = 1'b1;

  localparam logic OWN_REQ0 = 1'b0;
  localparam logic OWN_REQ1 = 1'b1;

  // The counter only ever holds 0..value-1, so ceil(log2(value)) bits suffice.
  // A value of 1 still gets one bit so the counter is never zero-width.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/MUX_2to1.sv
// -----------------------------------------------------------------------------
// MUX_2to1
// Plain 2-to-1 multiplexer shared across the datapath blocks.
// Ports:
//   i_a   [size] : selected when i_sel == 0
//   i_b   [size] : selected when i_sel == 1
//   i_sel        : select
//   o_y   [size] : selected value
// -----------------------------------------------------------------------------
module MUX_2to1 #(
  parameter int size = 32
) (
  input  logic [size-1:0] i_a,
  input  logic [size-1:0] i_b,
  input  logic            i_sel,
  output logic [size-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/rr_mux_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter_2to1
// Shares one size-bit datapath between two valid/ready requesters. A granted
// requester keeps the path until its last beat or until MAX_BURST beats have
// been taken, after which the path is re-arbitrated. The output beat is
// registered in front of a single downstream consumer.
//
// Build option:
//   RR_MUX_ARB_FIXED_PRIO_EN : req0 always wins contention and no round-robin
//                              pointer is kept. Undefined: round-robin.
//
// Ports:
//   clk_i, rst_i                   : clock, synchronous active-low reset
//   reqN_valid_i/data_i/last_i     : requester N beat
//   reqN_ready_o                   : requester N beat accepted (with valid)
//   data_o/valid_o/last_o, ready_i : registered downstream beat + handshake
//   select_o                       : current owner, mux select (0=req0)
//   busy_o                         : high while a grant is held
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no owner; pick a winner from the valid requesters, no data taken
// ST_LOCK | select_o owns the path; beats flow until last or the burst cap
// -----------------------------------------------------------------------------
module rr_mux_arbiter_2to1
  import rr_mux_arbiter_2to1_pkg::*;
#(
  parameter int size      = 32,
  parameter int MAX_BURST = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req0_valid_i,
  input  logic [size-1:0] req0_data_i,
  input  logic            req0_last_i,
  output logic            req0_ready_o,
  input  logic            req1_valid_i,
  input  logic [size-1:0] req1_data_i,
  input  logic            req1_last_i,
  output logic            req1_ready_o,
  output logic [size-1:0] data_o,
  output logic            valid_o,
  output logic            last_o,
  input  logic            ready_i,
  output logic            select_o,
  output logic            busy_o
);

  localparam int               CNT_W    = clog2(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic             r_state;
  logic             r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             r_last;
  logic [size-1:0]  r_data;
`ifndef RR_MUX_ARB_FIXED_PRIO_EN
  logic             r_ptr;
`endif

  logic             w_lock;
  logic             w_slot;
  logic             w_own_valid;
  logic             w_accept;
  logic             w_release;
  logic             w_any_valid;
  logic             w_win;
  logic [size-1:0]  w_mux_data;
  logic             w_mux_last;

  MUX_2to1 #(.size(size)) u_mux_data (
    .i_a   (req0_data_i),
    .i_b   (req1_data_i),
    .i_sel (r_sel),
    .o_y   (w_mux_data)
  );

  MUX_2to1 #(.size(1)) u_mux_last (
    .i_a   (req0_last_i),
    .i_b   (req1_last_i),
    .i_sel (r_sel),
    .o_y   (w_mux_last)
  );

  assign w_lock      = (r_state == ST_LOCK);
  // Output register can take a beat when it is empty or being drained now.
  assign w_slot      = !r_valid || ready_i;
  assign w_own_valid = (r_sel == OWN_REQ1) ? req1_valid_i : req0_valid_i;
  assign w_accept    = w_lock && w_own_valid && w_slot;
  // The cap releases the grant without marking last; the rest of the packet
  // simply competes again.
  assign w_release   = w_accept && (w_mux_last || (r_cnt == CNT_LAST));
  assign w_any_valid = req0_valid_i || req1_valid_i;

  // Ready is a function of registered state and ready_i only, so there is no
  // path from reqN_valid_i to reqN_ready_o.
  assign req0_ready_o = w_lock && (r_sel == OWN_REQ0) && w_slot;
  assign req1_ready_o = w_lock && (r_sel == OWN_REQ1) && w_slot;

  always_comb begin
    w_win = OWN_REQ0;
    if (req0_valid_i && req1_valid_i) begin
`ifdef RR_MUX_ARB_FIXED_PRIO_EN
      w_win = OWN_REQ0;
`else
      w_win = r_ptr;
`endif
    end else if (req1_valid_i) begin
      w_win = OWN_REQ1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_sel   <= OWN_REQ0;
      r_cnt   <= '0;
`ifndef RR_MUX_ARB_FIXED_PRIO_EN
      r_ptr   <= OWN_REQ0;
`endif
    end else if (r_state == ST_IDLE) begin
      if (w_any_valid) begin
        r_sel   <= w_win;
        r_state <= ST_LOCK;
        r_cnt   <= '0;
      end
    end else if (w_accept) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_release) begin
        r_state <= ST_IDLE;
`ifndef RR_MUX_ARB_FIXED_PRIO_EN
        r_ptr   <= ~r_sel;
`endif
      end
    end
  end

  // Output beat register: loads on accept, holds while stalled, empties when
  // the consumer takes the beat and nothing new arrives.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_last  <= w_mux_last;
      r_data  <= w_mux_data;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign data_o   = r_data;
  assign valid_o  = r_valid;
  assign last_o   = r_last;
  assign select_o = r_sel;
  assign busy_o   = w_lock;

endmodule

// File: tb/tb_rr_mux_arbiter_2to1.sv
module tb_rr_mux_arbiter_2to1;

  localparam int W    = 32;
  localparam int MAXB = 16;
`ifdef RR_MUX_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req0_valid_i, req0_last_i, req0_ready_o;
  logic [W-1:0] req0_data_i;
  logic         req1_valid_i, req1_last_i, req1_ready_o;
  logic [W-1:0] req1_data_i;
  logic [W-1:0] data_o;
  logic         valid_o, last_o, ready_i, select_o, busy_o;

  always #5 clk_i = ~clk_i;

  rr_mux_arbiter_2to1 #(.size(W), .MAX_BURST(MAXB)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_data_i  (req0_data_i),
    .req0_last_i  (req0_last_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_data_i  (req1_data_i),
    .req1_last_i  (req1_last_i),
    .req1_ready_o (req1_ready_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .last_o       (last_o),
    .ready_i      (ready_i),
    .select_o     (select_o),
    .busy_o       (busy_o)
  );

  int    n_checks = 0;
  int    n_err    = 0;
  int    cyc      = 0;
  int    acc_cnt  = 0;
  int    gap0     = 0;
  int    m_ptr    = 0;
  bit    hs0      = 1'b0;
  bit    hs1      = 1'b0;
  beat_t q0[$];
  beat_t q1[$];
  beat_t exp_q[$];
  bit    exp_own[$];
  int    out_cyc[$];
  bit           have_prev = 1'b0;
  logic         prev_valid, prev_ready, prev_last;
  logic [W-1:0] prev_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_checks++;
    n_err++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic beat_t mk(input logic l, input logic [W-1:0] d);
    beat_t b;
    b.last = l;
    b.data = d;
    return b;
  endfunction

  // Transaction-level model: both requesters present their queued beats from
  // the start, so the grant order follows purely from the arbitration rules.
  task automatic build_model();
    beat_t a[$];
    beat_t b[$];
    beat_t x;
    int    w;
    int    n;
    a = q0;
    b = q1;
    while (a.size() > 0 || b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) w = FIXED ? 0 : m_ptr;
      else w = (a.size() > 0) ? 0 : 1;
      n = 0;
      do begin
        if (w == 0) x = a.pop_front();
        else x = b.pop_front();
        exp_q.push_back(x);
        exp_own.push_back(w[0]);
        n++;
      end while (!x.last && n < MAXB && ((w == 0) ? a.size() : b.size()) > 0);
      m_ptr = 1 - w;
    end
  endtask

  task automatic drive();
    req0_valid_i = (q0.size() > 0) && (gap0 == 0);
    req0_data_i  = (q0.size() > 0) ? q0[0].data : '0;
    req0_last_i  = (q0.size() > 0) ? q0[0].last : 1'b0;
    req1_valid_i = (q1.size() > 0);
    req1_data_i  = (q1.size() > 0) ? q1[0].data : '0;
    req1_last_i  = (q1.size() > 0) ? q1[0].last : 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    if (hs0) begin void'(q0.pop_front()); acc_cnt++; end
    if (hs1) begin void'(q1.pop_front()); acc_cnt++; end
    if (gap0 > 0) gap0--;
    drive();
  endtask

  function automatic bit pending();
    return (exp_q.size() > 0 || exp_own.size() > 0 || q0.size() > 0 || q1.size() > 0);
  endfunction

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (pending() && k < budget) begin
      step();
      k++;
    end
    if (pending()) begin
      fail("drain_timeout", $sformatf("%0d output beats still outstanding", exp_q.size()));
      exp_q.delete(); exp_own.delete(); q0.delete(); q1.delete();
      drive();
    end
    repeat (2) step();
  endtask

  task automatic wait_acc(input int target, input string name);
    int k;
    k = 0;
    while (acc_cnt < target && k < 40) begin
      step();
      k++;
    end
    if (acc_cnt < target) fail(name, $sformatf("only %0d accepts, need %0d", acc_cnt, target));
  endtask

  task automatic apply_reset();
    rst_i = 1'b0;
    q0.delete(); q1.delete();
    gap0 = 0;
    drive();
    repeat (2) step();
    rst_i = 1'b1;
    exp_q.delete(); exp_own.delete();
    m_ptr = 0;
  endtask

  // Compare process: samples at the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    bit o;
    if (!rst_i) begin
      hs0 = 1'b0;
      hs1 = 1'b0;
      have_prev = 1'b0;
    end else begin
      hs0 = req0_valid_i && req0_ready_o;
      hs1 = req1_valid_i && req1_ready_o;
      chk("ready_pair", 64'(req0_ready_o & req1_ready_o), 64'(0));
      if (hs0 || hs1) begin
        if (exp_own.size() == 0) begin
          fail("accept_extra", $sformatf("unexpected accept from req%0d", hs1));
        end else begin
          o = exp_own.pop_front();
          chk("accept_owner", 64'(hs1), 64'(o));
          chk("select_at_accept", 64'(select_o), 64'(o));
        end
      end
      if (valid_o && ready_i) begin
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) fail("out_extra", $sformatf("got data 0x%0h, no beat expected", data_o));
        else chk("out_beat", 64'({last_o, data_o}), 64'(exp_q.pop_front()));
      end
      if (have_prev && prev_valid && !prev_ready)
        chk("stall_hold", 64'({valid_o, last_o, data_o}), 64'({1'b1, prev_last, prev_data}));
      have_prev  = 1'b1;
      prev_valid = valid_o;
      prev_ready = ready_i;
      prev_last  = last_o;
      prev_data  = data_o;
    end
  end

  initial begin
    int t0;
    int base;
    logic [5:0] v6;
    logic [3:0] v4;

    rst_i   = 1'b0;
    ready_i = 1'b1;
    drive();
    repeat (3) step();
    rst_i = 1'b1;

    // Reset state
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_data", 64'(data_o), 64'(0));
    chk("rst_last", 64'(last_o), 64'(0));
    chk("rst_select", 64'(select_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_ready", 64'({req0_ready_o, req1_ready_o}), 64'(0));

    // T1: single beat latency
    step();
    q0.push_back(mk(1'b1, 32'hA5A5_0001));
    build_model();
    drive();
    step();
    chk("t1_arb_busy", 64'(busy_o), 64'(1));
    chk("t1_arb_valid", 64'(valid_o), 64'(0));
    chk("t1_arb_select", 64'(select_o), 64'(0));
    chk("t1_arb_ready0", 64'(req0_ready_o), 64'(1));
    step();
    chk("t1_valid", 64'(valid_o), 64'(1));
    chk("t1_data", 64'(data_o), 64'(32'hA5A5_0001));
    chk("t1_last", 64'(last_o), 64'(1));
    chk("t1_busy_drop", 64'(busy_o), 64'(0));
    step();
    chk("t1_valid_drop", 64'(valid_o), 64'(0));
    drain(40);

    // T2: both valid from reset, 3-beat packets each
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(i == 2, 32'h0000_0A00 + i));
      q1.push_back(mk(i == 2, 32'h0000_0B00 + i));
    end
    build_model();
    v6 = '0;
    for (int i = 0; i < 6 && i < exp_own.size(); i++) v6[i] = exp_own[i];
    chk("pin_t2_owner", 64'(v6), 64'(6'b111000));
    if (exp_q.size() > 3) chk("pin_t2_beat3", 64'(exp_q[3]), 64'({1'b0, 32'h0000_0B00}));
    out_cyc.delete();
    drive();
    t0 = cyc;
    drain(60);
    if (out_cyc.size() < 6) begin
      fail("t2_beats", $sformatf("saw %0d output beats, need 6", out_cyc.size()));
    end else begin
      chk("t2_first_latency", 64'(out_cyc[0] - t0), 64'(2));
      chk("t2_dead_cycle", 64'(out_cyc[3] - out_cyc[2]), 64'(2));
      chk("t2_back_to_back", 64'(out_cyc[5] - out_cyc[3]), 64'(2));
    end

    // T3: downstream stall mid-packet, then owner valid gap
    for (int i = 0; i < 4; i++) q0.push_back(mk(i == 3, 32'hC0DE_0000 + i));
    build_model();
    drive();
    base = acc_cnt;
    wait_acc(base + 2, "t3_wait_two");
    ready_i = 1'b0;
    repeat (4) begin
      step();
      chk("t3_stall_ready0", 64'(req0_ready_o), 64'(0));
      chk("t3_stall_valid", 64'(valid_o), 64'(1));
    end
    ready_i = 1'b1;
    wait_acc(base + 3, "t3_wait_three");
    gap0 = 3;
    drive();
    repeat (3) begin
      step();
      chk("t3_gap_busy", 64'(busy_o), 64'(1));
      chk("t3_gap_select", 64'(select_o), 64'(0));
    end
    drain(40);

    // T4: req1 20-beat packet hits the burst cap while req0 waits
    for (int i = 0; i < 20; i++) q1.push_back(mk(i == 19, 32'hB000_0000 + i));
    for (int i = 0; i < 2; i++) q0.push_back(mk(i == 1, 32'hA000_0000 + i));
    build_model();
    chk("pin_t4_len", 64'(exp_own.size()), 64'(22));
    if (exp_own.size() == 22) begin
`ifdef RR_MUX_ARB_FIXED_PRIO_EN
      chk("pin_t4_own0", 64'(exp_own[0]), 64'(0));
      chk("pin_t4_own2", 64'(exp_own[2]), 64'(1));
      chk("pin_t4_own18", 64'(exp_own[18]), 64'(1));
`else
      chk("pin_t4_own15", 64'(exp_own[15]), 64'(1));
      chk("pin_t4_own16", 64'(exp_own[16]), 64'(0));
      chk("pin_t4_own18", 64'(exp_own[18]), 64'(1));
      chk("pin_t4_cap_last", 64'(exp_q[15].last), 64'(0));
`endif
    end
    drive();
    drain(200);

    // Single req0 packet so the pointer favours req1 before the reset test
    q0.push_back(mk(1'b1, 32'h0000_5555));
    build_model();
    drive();
    drain(40);

    // T5: reset during beat 2 of a 5-beat burst
    for (int i = 0; i < 5; i++) q0.push_back(mk(i == 4, 32'hD000_0000 + i));
    build_model();
    drive();
    base = acc_cnt;
    wait_acc(base + 2, "t5_wait_two");
    rst_i = 1'b0;
    q0.delete(); q1.delete();
    drive();
    step();
    chk("t5_valid", 64'(valid_o), 64'(0));
    chk("t5_busy", 64'(busy_o), 64'(0));
    chk("t5_select", 64'(select_o), 64'(0));
    chk("t5_last", 64'(last_o), 64'(0));
    chk("t5_data", 64'(data_o), 64'(0));
    exp_q.delete(); exp_own.delete();
    m_ptr = 0;
    rst_i = 1'b1;

    // T6: fresh arbitration, both valid with 1-beat packets
    for (int i = 0; i < 2; i++) begin
      q0.push_back(mk(1'b1, 32'hE000_0000 + i));
      q1.push_back(mk(1'b1, 32'hF000_0000 + i));
    end
    build_model();
    v4 = '0;
    for (int i = 0; i < 4 && i < exp_own.size(); i++) v4[i] = exp_own[i];
`ifdef RR_MUX_ARB_FIXED_PRIO_EN
    chk("pin_t6_owner", 64'(v4), 64'(4'b1100));
`else
    chk("pin_t6_owner", 64'(v4), 64'(4'b1010));
`endif
    drive();
    drain(60);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter_2to1.md
Name: rr_mux_arbiter_2to1

Overview:
- Arbiter and sequencer that shares one `size`-bit datapath between two requesters. It drives the select of the team's 2-to-1 mux.
- Uses valid/ready handshakes with a packet lock, so a granted requester keeps the path until its `last` beat or the burst cap.
- Round-robin between requesters.
- Output is registered and sits in front of a shared downstream consumer (e.g. a write port or bus).

Parameters:
size, 32, data width of each requester and of data_o
MAX_BURST, 16, max beats per grant before forced re-arbitration (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-low
req0_valid_i  in  1  requester 0 beat valid
req0_data_i  in  size  requester 0 beat data
req0_last_i  in  1  requester 0 final beat of packet
req0_ready_o  out  1  requester 0 beat accepted this cycle when high with valid
req1_valid_i  in  1  requester 1 beat valid
req1_data_i  in  size  requester 1 beat data
req1_last_i  in  1  requester 1 final beat of packet
req1_ready_o  out  1  requester 1 beat accepted
data_o  out  size  registered output data
valid_o  out  1  output beat valid
last_o  out  1  output beat is packet end
ready_i  in  1  downstream accepts beat
select_o  out  1  current owner, 0=req0, 1=req1 (mux select)
busy_o  out  1  high while in LOCK

Behaviour:
- Reset (rst_i==0 at clk edge) forces the following, discarding any burst in flight:
  - state=IDLE, valid_o=0, data_o=0, last_o=0, select_o=0, busy_o=0, beat count=0.
  - Priority pointer favours req0 next.
- FSM states:
  - IDLE: no ready asserted.
    - If any reqN_valid_i, pick the winner: a single valid requester wins; if both are valid, the pointer side wins.
    - Register the winner into select_o, go to LOCK, clear the beat counter. No data is accepted in this arbitration cycle.
  - LOCK: reqN_ready_o = (select_o==N) && (!valid_o || ready_i). The non-owner's ready is 0.
    - On accept: data_o<=selected data, last_o<=selected last, valid_o<=1, count++.
    - Exit to IDLE on accept with last=1 or count==MAX_BURST-1. Set pointer to the non-owner.
    - Owner valid low mid-packet: stay in LOCK and wait, with no timeout.
- Output register:
  - valid_o && !ready_i: data_o and last_o hold stable.
  - ready_i with no new accept: valid_o<=0.
- Latency: 2 cycles from first reqN_valid_i to valid_o (arbitrate, then register). Back-to-back beats within a grant run at 1 per cycle when ready_i=1.
- Back-to-back grants: one dead IDLE cycle per grant change.
- Forced release at MAX_BURST:
  - last_o reflects only the input last; no synthetic last is inserted.
  - The remainder of the packet is re-arbitrated.
  - The other requester gets the path if it is valid; otherwise the same requester is re-granted.
- Both valid in IDLE with the pointer at req1: req1 wins and req0 waits one full grant.
- No combinational path from reqN_valid_i to reqN_ready_o in IDLE. In LOCK, ready depends on ready_i combinationally.

Optional Feature:
- RR_MUX_ARB_FIXED_PRIO_EN defined: req0 always wins contention in IDLE and the pointer is ignored. The burst cap still forces re-arbitration, but req0 may immediately re-win.
- Not defined: round-robin as above.

Decomposition:
- Shared package holds:
  - FSM state encoding ST_IDLE=1'b0, ST_LOCK=1'b1.
  - Owner encodings OWN_REQ0=1'b0, OWN_REQ1=1'b1.
  - Beat-counter width function clog2(MAX_BURST).
- Sub-module: instantiate the existing MUX_2to1 (size=size) for data selection and a second instance (size=1) for last, both driven by select_o. Arbiter logic stays in this module.

Test Plan:
- Reset then req0 single beat data=32'hA5A5_0001, last=1, ready_i=1 -> valid_o at cycle 2, data_o=32'hA5A5_0001, last_o=1, busy_o drops next cycle.
- Both valid from reset, each a 3-beat packet -> req0 packet (3 beats) then IDLE cycle then req1 packet; select_o 0 then 1; no interleaving.
- ready_i=0 for 4 cycles mid-packet -> data_o/last_o stable, owner ready low, no beat lost or duplicated; scoreboard order matches.
- req1 sends 20 beats without last, req0 valid, MAX_BURST=16 -> after 16 req1 beats, grant to req0 packet, then remaining 4 req1 beats.
- rst_i=0 during beat 2 of a 5-beat burst -> next cycle valid_o=0, busy_o=0, select_o=0; fresh arbitration after release.
- With RR_MUX_ARB_FIXED_PRIO_EN, both valid continuously with 1-beat packets -> req0 granted every time; without it, grants alternate 0,1,0,1.
